// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - Shared register map, bit positions and bus FSM encoding for the debug module slave
package dm_pkg;

   localparam logic [31:0] ADDR_DATA0     = 32'h04;
   localparam logic [31:0] ADDR_DMCONTROL = 32'h10;
   localparam logic [31:0] ADDR_DMSTATUS  = 32'h11;

   localparam int DMCTL_HALTREQ     = 31;
   localparam int DMCTL_RESUMEREQ   = 30;
   localparam int DMCTL_HARTRESET   = 29;
   localparam int DMCTL_HARTSEL_LSB = 16;
   localparam int DMCTL_HARTSEL_W   = 4;
   localparam int DMCTL_DMACTIVE    = 0;

   localparam logic [3:0] DMSTATUS_VERSION = 4'd2;
   localparam int DMS_ANYHALTED      = 8;
   localparam int DMS_ALLHALTED      = 9;
   localparam int DMS_ANYRUNNING     = 10;
   localparam int DMS_ALLRUNNING     = 11;
   localparam int DMS_ANYNONEXISTENT = 14;
   localparam int DMS_ANYRESUMEACK   = 16;
   localparam int DMS_ALLRESUMEACK   = 17;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } bus_state_t;

   // Trace code for a dmcontrol write: halt beats resume beats reset
   function automatic logic [7:0] printf_code(input logic halt, input logic resume, input logic reset);
      if (halt)   return 8'h00;
      if (resume) return 8'h01;
      if (reset)  return 8'h02;
      return 8'h03;
   endfunction

endpackage

// File: rtl/dm_wb_slave_if.sv
// rtl/dm_wb_slave_if.sv - Wishbone request/response bundle between bus master and debug module slave
interface dm_wb_slave_if #(
   parameter int DATA_WIDTH = 64
);
   logic [31:0]           addr_i;
   logic                  we_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  cyc_i;
   logic                  stb_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  ack_o;

   modport master (
      output addr_i, we_i, data_i, cyc_i, stb_i,
      input  data_o, ack_o
   );

   modport slave (
      input  addr_i, we_i, data_i, cyc_i, stb_i,
      output data_o, ack_o
   );
endinterface

// File: rtl/dm_hart_ctrl.sv
// rtl/dm_hart_ctrl.sv - Per-hart halt/reset request levels, one-cycle resume pulse and resumeack tracking
module dm_hart_ctrl (
   input  logic clk_i,
   input  logic rst_i,
   input  logic selected,
   input  logic dmactive,
   input  logic haltreq,
   input  logic hartreset,
   input  logic resume_go,
   input  logic hart_halted,
   output logic halt_req,
   output logic reset_req,
   output logic resume_pulse,
   output logic resume_ack
);

   logic pending_q;

   assign halt_req  = selected & dmactive & haltreq;
   assign reset_req = selected & dmactive & hartreset;

   // Resume pulse for one cycle, then ack once the hart is seen running; a new resume outranks deactivation
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         resume_pulse <= 1'b0;
         pending_q    <= 1'b0;
         resume_ack   <= 1'b0;
      end else if (resume_go) begin
         resume_pulse <= 1'b1;
         pending_q    <= 1'b1;
         resume_ack   <= 1'b0;
      end else if (!dmactive) begin
         resume_pulse <= 1'b0;
         pending_q    <= 1'b0;
         resume_ack   <= 1'b0;
      end else begin
         resume_pulse <= 1'b0;
         if (pending_q && !hart_halted) begin
            resume_ack <= 1'b1;
            pending_q  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dm_wb_slave.sv
// rtl/dm_wb_slave.sv - Debug module Wishbone slave (dmcontrol, dmstatus, dataN); DM_WB_SLAVE_PRINTF_EN adds send_data/printf
module dm_wb_slave
   import dm_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_HARTS  = 4,
   parameter int NUM_DATA   = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   dm_wb_slave_if.slave         bus,
   input  logic [NUM_HARTS-1:0] hart_halted_i,
   output logic [NUM_HARTS-1:0] haltreq_o,
   output logic [NUM_HARTS-1:0] resumereq_o,
   output logic [NUM_HARTS-1:0] hartreset_o
`ifdef DM_WB_SLAVE_PRINTF_EN
   ,
   output logic [7:0]           send_data,
   output logic                 printf
`endif
);

   bus_state_t state_q, state_d;
   logic req, start, wr_commit, dmctl_wr, resume_go_any;

   logic                       dmactive_q, haltreq_q, hartreset_q;
   logic                       dmactive_d, haltreq_d, hartreset_d;
   logic [DMCTL_HARTSEL_W-1:0] hartsel_q, hartsel_d, wr_hartsel;
   logic [DATA_WIDTH-1:0]      data_q [NUM_DATA];
   logic [DATA_WIDTH-1:0]      data_d [NUM_DATA];

   logic [NUM_HARTS-1:0]  resumeack;
   logic                  hartsel_valid, sel_halted, sel_ack;
   logic [31:0]           dmcontrol_rd, dmstatus;
   logic [DATA_WIDTH-1:0] rdata, data_o_q;
   logic                  ack_q;

   assign req           = bus.cyc_i & bus.stb_i;
   assign start         = (state_q == ST_IDLE) & req;
   assign wr_commit     = start & bus.we_i;
   assign dmctl_wr      = wr_commit & (bus.addr_i == ADDR_DMCONTROL);
   assign wr_hartsel    = bus.data_i[DMCTL_HARTSEL_LSB +: DMCTL_HARTSEL_W];
   assign resume_go_any = dmctl_wr & bus.data_i[DMCTL_RESUMEREQ] & ~bus.data_i[DMCTL_HALTREQ]
                          & bus.data_i[DMCTL_DMACTIVE];
   assign hartsel_valid = ({28'd0, hartsel_q} < 32'(NUM_HARTS));

   // Bus FSM next state: one ack per request, re-arm only after cyc/stb drop
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req)  state_d = ST_ACK;
         ST_ACK:  if (!req) state_d = ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
   end

   // Bus state, registered ack and read data latched at the accepting edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         ack_q    <= 1'b0;
         data_o_q <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= (state_d == ST_ACK);
         if (start)
            data_o_q <= rdata;
         else if (state_d == ST_IDLE)
            data_o_q <= '0;
      end
   end

   assign bus.ack_o  = ack_q;
   assign bus.data_o = data_o_q;

   // Post-write register values; a dmcontrol write without dmactive only clears, data is zero while inactive
   always_comb begin
      dmactive_d  = dmactive_q;
      haltreq_d   = haltreq_q;
      hartreset_d = hartreset_q;
      hartsel_d   = hartsel_q;
      if (dmctl_wr) begin
         dmactive_d  = bus.data_i[DMCTL_DMACTIVE];
         haltreq_d   = bus.data_i[DMCTL_HALTREQ]   & bus.data_i[DMCTL_DMACTIVE];
         hartreset_d = bus.data_i[DMCTL_HARTRESET] & bus.data_i[DMCTL_DMACTIVE];
         hartsel_d   = bus.data_i[DMCTL_DMACTIVE] ? wr_hartsel : '0;
      end
      for (int i = 0; i < NUM_DATA; i++) begin
         data_d[i] = dmactive_q ? data_q[i] : '0;
         if (wr_commit && dmactive_q && (bus.addr_i == ADDR_DATA0 + 32'(i)))
            data_d[i] = bus.data_i;
      end
   end

   // Register file update
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dmactive_q  <= 1'b0;
         haltreq_q   <= 1'b0;
         hartreset_q <= 1'b0;
         hartsel_q   <= '0;
         for (int i = 0; i < NUM_DATA; i++) data_q[i] <= '0;
      end else begin
         dmactive_q  <= dmactive_d;
         haltreq_q   <= haltreq_d;
         hartreset_q <= hartreset_d;
         hartsel_q   <= hartsel_d;
         for (int i = 0; i < NUM_DATA; i++) data_q[i] <= data_d[i];
      end
   end

   // dmcontrol readback (resumereq is write-only) and dmstatus summarised over the selected hart
   always_comb begin
      dmcontrol_rd                 = '0;
      dmcontrol_rd[DMCTL_HALTREQ]   = haltreq_d;
      dmcontrol_rd[DMCTL_HARTRESET] = hartreset_d;
      dmcontrol_rd[DMCTL_HARTSEL_LSB +: DMCTL_HARTSEL_W] = hartsel_d;
      dmcontrol_rd[DMCTL_DMACTIVE]  = dmactive_d;

      sel_halted = 1'b0;
      sel_ack    = 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (hartsel_q == 4'(h)) begin
            sel_halted = hart_halted_i[h];
            sel_ack    = resumeack[h];
         end
      end
      dmstatus      = '0;
      dmstatus[3:0] = DMSTATUS_VERSION;
      if (hartsel_valid) begin
         dmstatus[DMS_ANYHALTED]    = sel_halted;
         dmstatus[DMS_ALLHALTED]    = sel_halted;
         dmstatus[DMS_ANYRUNNING]   = ~sel_halted;
         dmstatus[DMS_ALLRUNNING]   = ~sel_halted;
         dmstatus[DMS_ANYRESUMEACK] = sel_ack;
         dmstatus[DMS_ALLRESUMEACK] = sel_ack;
      end else begin
         dmstatus[DMS_ANYNONEXISTENT] = 1'b1;
      end
   end

   // Read mux over post-write values; unmapped addresses read zero
   always_comb begin
      rdata = '0;
      if (bus.addr_i == ADDR_DMCONTROL)
         rdata[31:0] = dmcontrol_rd;
      else if (bus.addr_i == ADDR_DMSTATUS)
         rdata[31:0] = dmstatus;
      else
         for (int i = 0; i < NUM_DATA; i++)
            if (bus.addr_i == ADDR_DATA0 + 32'(i)) rdata = data_d[i];
   end

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      logic selected, resume_go;
      assign selected  = (hartsel_q == 4'(h));
      assign resume_go = resume_go_any & (wr_hartsel == 4'(h));

      dm_hart_ctrl u_hart (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .selected     (selected),
         .dmactive     (dmactive_q),
         .haltreq      (haltreq_q),
         .hartreset    (hartreset_q),
         .resume_go    (resume_go),
         .hart_halted  (hart_halted_i[h]),
         .halt_req     (haltreq_o[h]),
         .reset_req    (hartreset_o[h]),
         .resume_pulse (resumereq_o[h]),
         .resume_ack   (resumeack[h])
      );
   end

`ifdef DM_WB_SLAVE_PRINTF_EN
   // Trace every committed dmcontrol write: code byte plus toggle strobe
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         send_data <= 8'h00;
         printf    <= 1'b0;
      end else if (dmctl_wr) begin
         send_data <= printf_code(bus.data_i[DMCTL_HALTREQ], bus.data_i[DMCTL_RESUMEREQ],
                                  bus.data_i[DMCTL_HARTRESET]);
         printf    <= ~printf;
      end
   end
`endif

endmodule

// File: tb/tb_dm_wb_slave.sv
// tb/tb_dm_wb_slave.sv - Self-checking bench for dm_wb_slave: per-cycle model compare plus directed literal checks
module tb_dm_wb_slave;

   localparam int DW = 64;
   localparam int NH = 4;
   localparam int ND = 2;

   logic clk_i = 1'b0;
   logic rst_i;
   logic [NH-1:0] hart_halted_i, haltreq_o, resumereq_o, hartreset_o;
`ifdef DM_WB_SLAVE_PRINTF_EN
   logic [7:0] send_data;
   logic       printf;
`endif

   always #5 clk_i = ~clk_i;

   dm_wb_slave_if #(.DATA_WIDTH(DW)) bus ();

   dm_wb_slave #(.DATA_WIDTH(DW), .NUM_HARTS(NH), .NUM_DATA(ND)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .bus           (bus),
      .hart_halted_i (hart_halted_i),
      .haltreq_o     (haltreq_o),
      .resumereq_o   (resumereq_o),
      .hartreset_o   (hartreset_o)
`ifdef DM_WB_SLAVE_PRINTF_EN
      ,
      .send_data     (send_data),
      .printf        (printf)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: transaction-level view of the register map and hart handshake
   logic          m_busy, m_ack, m_active, m_halt, m_hreset;
   int            m_sel;
   logic [DW-1:0] m_data_o;
   logic [DW-1:0] m_dreg [ND];
   logic [NH-1:0] m_rack, m_pend, m_pulse;

   task automatic model_reset();
      m_busy = 0; m_ack = 0; m_active = 0; m_halt = 0; m_hreset = 0; m_sel = 0;
      m_data_o = '0; m_rack = '0; m_pend = '0; m_pulse = '0;
      for (int i = 0; i < ND; i++) m_dreg[i] = '0;
   endtask

   function automatic logic [DW-1:0] model_status();
      logic [DW-1:0] s;
      s = 64'h2;
      if (m_sel >= NH) s = s | 64'h4000;
      else begin
         if (hart_halted_i[m_sel]) s = s | 64'h300;
         else                      s = s | 64'hC00;
         if (m_rack[m_sel])        s = s | 64'h30000;
      end
      return s;
   endfunction

   function automatic logic [NH-1:0] sel_mask(input logic en);
      logic [NH-1:0] m;
      m = '0;
      if (en && m_sel < NH) m[m_sel] = 1'b1;
      return m;
   endfunction

   task automatic model_step();
      logic          req, old_active;
      logic [DW-1:0] st, rd, wd;
      logic [31:0]   a;
      req = bus.cyc_i && bus.stb_i;
      a = bus.addr_i;
      wd = bus.data_i;
      st = model_status();
      old_active = m_active;
      m_pulse = '0;
      if (!old_active) begin
         m_rack = '0; m_pend = '0;
         for (int i = 0; i < ND; i++) m_dreg[i] = '0;
      end else begin
         for (int h = 0; h < NH; h++)
            if (m_pend[h] && !hart_halted_i[h]) begin m_rack[h] = 1; m_pend[h] = 0; end
      end
      if (!m_busy && req) begin
         m_busy = 1;
         if (bus.we_i) begin
            if (a == 32'h10) begin
               m_active = wd[0];
               m_halt   = wd[31] && wd[0];
               m_hreset = wd[29] && wd[0];
               m_sel    = wd[0] ? int'(wd[19:16]) : 0;
               if (wd[0] && wd[30] && !wd[31] && m_sel < NH) begin
                  m_pulse[m_sel] = 1; m_pend[m_sel] = 1; m_rack[m_sel] = 0;
               end
            end else if (a >= 4 && a < 4 + ND && old_active) begin
               m_dreg[a-4] = wd;
            end
         end
         rd = '0;
         if (a == 32'h10)
            rd = {32'b0, m_halt, 1'b0, m_hreset, 9'b0, 4'(m_sel), 15'b0, m_active};
         else if (a == 32'h11)
            rd = st;
         else if (a >= 4 && a < 4 + ND)
            rd = m_dreg[a-4];
         m_data_o = rd;
      end else if (m_busy && !req) begin
         m_busy = 0;
         m_data_o = '0;
      end
      m_ack = m_busy;
   endtask

   // Advance the model on each edge, compare all outputs mid-cycle
   initial begin
      model_reset();
      forever begin
         @(posedge clk_i);
         if (rst_i) model_reset();
         else       model_step();
         @(negedge clk_i);
         check("cyc_ack",       64'(bus.ack_o),     64'(m_ack));
         check("cyc_data",      bus.data_o,         m_data_o);
         check("cyc_haltreq",   64'(haltreq_o),     64'(sel_mask(m_halt)));
         check("cyc_hartreset", 64'(hartreset_o),   64'(sel_mask(m_hreset)));
         check("cyc_resumereq", 64'(resumereq_o),   64'(m_pulse));
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wb_access(input logic [31:0] a, input logic w, input logic [DW-1:0] d,
                            output logic [DW-1:0] rd, output int lat);
      tick();
      bus.addr_i = a; bus.we_i = w; bus.data_i = d; bus.cyc_i = 1; bus.stb_i = 1;
      lat = 0;
      while (lat < 8) begin
         tick();
         lat++;
         if (bus.ack_o) break;
      end
      check("ack_seen", 64'(bus.ack_o), 64'h1);
      rd = bus.data_o;
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
   endtask

   logic [DW-1:0] rd;
   int            lat;
   logic [12:0]   ackv;

   initial begin
      rst_i = 1; hart_halted_i = '0;
      bus.addr_i = '0; bus.we_i = 0; bus.data_i = '0; bus.cyc_i = 0; bus.stb_i = 0;
      tick(); tick();
      check("rst_ack",     64'(bus.ack_o),   64'h0);
      check("rst_data",    bus.data_o,       64'h0);
      check("rst_haltreq", 64'(haltreq_o),   64'h0);
      rst_i = 0;

      // Halt hart 0, then read status with it halted
      wb_access(32'h10, 1, 64'h8000_0001, rd, lat);
      check("w_latency",   64'(lat),       64'h1);
      check("halt_h0",     64'(haltreq_o), 64'h1);
      hart_halted_i = 4'b0001;
      wb_access(32'h11, 0, '0, rd, lat);
      check("status_halted", rd, 64'h302);

      // Resume hart 1, then let it run and observe resumeack
      hart_halted_i = 4'b0011;
      wb_access(32'h10, 1, 64'h4001_0001, rd, lat);
      check("resume_pulse",  64'(resumereq_o), 64'h2);
      check("dmctl_readbk",  rd,               64'h0001_0001);
      tick();
      check("resume_1cyc",   64'(resumereq_o), 64'h0);
      hart_halted_i = 4'b0001;
      tick(); tick();
      wb_access(32'h11, 0, '0, rd, lat);
      check("allresumeack",  64'(rd[17]),      64'h1);
      check("status_run",    rd,               64'h3_0C02);

      // stb held 10 cycles on a data0 write; data_i changes after commit must not land
      tick();
      bus.addr_i = 32'h04; bus.we_i = 1; bus.data_i = 64'hDEAD; bus.cyc_i = 1; bus.stb_i = 1;
      for (int c = 1; c <= 12; c++) begin
         if (c == 2)  bus.data_i = 64'hBEEF;
         if (c == 11) begin bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; end
         ackv[c] = bus.ack_o;
         tick();
      end
      check("hold_ack_c1", 64'(ackv[1]), 64'h0);
      for (int c = 2; c <= 10; c++) check("hold_ack_mid", 64'(ackv[c]), 64'h1);
      check("hold_ack_c12", 64'(ackv[12]), 64'h0);
      wb_access(32'h04, 0, '0, rd, lat);
      check("data0_single", rd, 64'hDEAD);

      // Nonexistent hart, then deactivate and confirm data is wiped and locked
      wb_access(32'h10, 1, 64'h0007_0001, rd, lat);
      wb_access(32'h11, 0, '0, rd, lat);
      check("status_nonexist", rd, 64'h4002);
      wb_access(32'h10, 1, 64'hA007_0001, rd, lat);
      check("nx_haltreq",   64'(haltreq_o),   64'h0);
      check("nx_hartreset", 64'(hartreset_o), 64'h0);
      wb_access(32'h05, 1, 64'h1234_5678_9ABC_DEF0, rd, lat);
      wb_access(32'h05, 0, '0, rd, lat);
      check("data1_rw", rd, 64'h1234_5678_9ABC_DEF0);
      wb_access(32'h10, 1, 64'h8000_0000, rd, lat);
      check("inactive_dmctl", rd, 64'h0);
      wb_access(32'h04, 1, 64'h55, rd, lat);
      wb_access(32'h04, 0, '0, rd, lat);
      check("inactive_data0", rd, 64'h0);
      wb_access(32'h05, 0, '0, rd, lat);
      wb_access(32'h20, 1, 64'hFFFF, rd, lat);
      wb_access(32'h20, 0, '0, rd, lat);
      check("unmapped_rd", rd, 64'h0);

      // Reset in the middle of an acked halt write, request still held
      hart_halted_i = '0;
      wb_access(32'h10, 1, 64'h0000_0001, rd, lat);
      tick();
      bus.addr_i = 32'h10; bus.we_i = 1; bus.data_i = 64'h8000_0001; bus.cyc_i = 1; bus.stb_i = 1;
      tick();
      check("pre_rst_ack",  64'(bus.ack_o),  64'h1);
      check("pre_rst_halt", 64'(haltreq_o),  64'h1);
      @(negedge clk_i);
      #2 rst_i = 1;
      #1;
      check("rst_ack_async",  64'(bus.ack_o), 64'h0);
      check("rst_halt_async", 64'(haltreq_o), 64'h0);
      tick();
      rst_i = 0;
      tick();
      check("retrig_ack",  64'(bus.ack_o), 64'h1);
      check("retrig_halt", 64'(haltreq_o), 64'h1);
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;

      // Halt and resume together: halt wins, no pulse
      wb_access(32'h10, 1, 64'hC000_0001, rd, lat);
      check("hr_halt",     64'(haltreq_o),   64'h1);
      check("hr_noresume", 64'(resumereq_o), 64'h0);
      tick();
      check("hr_noresume2", 64'(resumereq_o), 64'h0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dm_wb_slave.md
DM_WB_SLAVE -- requirements
Module: dm_wb_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, Wishbone data width (32 or 64).
REQ-002 SHALL have parameter NUM_HARTS, default 4, harts under control (1..16).
REQ-003 SHALL have parameter NUM_DATA, default 2, dataN registers (1..12).
REQ-004 SHALL have port clk_i  in  1  sole clock.
REQ-005 SHALL have port rst_i  in  1  reset; one clock, asynchronous, active-high.
REQ-006 SHALL have ports addr_i in 32, we_i in 1, data_i in DATA_WIDTH, cyc_i in 1, stb_i in 1: Wishbone slave request.
REQ-007 SHALL have ports data_o out DATA_WIDTH, ack_o out 1: Wishbone slave response.
REQ-008 SHALL have port hart_halted_i  in  NUM_HARTS  per-hart halted status, synchronous to clk_i.
REQ-009 SHALL have port haltreq_o  out  NUM_HARTS  per-hart level halt request.
REQ-010 SHALL have port resumereq_o  out  NUM_HARTS  per-hart one-cycle resume pulse.
REQ-011 SHALL have port hartreset_o  out  NUM_HARTS  per-hart level reset request.

Function
REQ-012 SHALL implement bus FSM states IDLE and ACK; IDLE->ACK when cyc_i&stb_i; ACK->IDLE when cyc_i or stb_i is low.
REQ-013 SHALL register ack_o: high from the cycle after the IDLE->ACK transition while in ACK, low in IDLE; request-to-ack latency 1 cycle.
REQ-014 SHALL commit a write exactly once, on the IDLE->ACK clock edge; holding stb_i in ACK causes no further writes.
REQ-015 SHALL latch data_o on the IDLE->ACK edge (reads and writes; on write, post-write value), hold it through ACK, and drive 0 in IDLE.
REQ-016 SHALL decode dmcontrol at 0x10 (rw): bit31 haltreq, bit30 resumereq (write-only, reads 0), bit29 hartreset, bits[19:16] hartsel, bit0 dmactive.
REQ-017 SHALL decode dmstatus at 0x11 (ro): [3:0]=2, bit8 anyhalted, bit9 allhalted, bit10 anyrunning, bit11 allrunning, bit14 anynonexistent, bit16 anyresumeack, bit17 allresumeack, computed over the selected hart.
REQ-018 SHALL decode data0..data(NUM_DATA-1) at 0x04..0x04+NUM_DATA-1 (rw, full DATA_WIDTH).
REQ-019 SHALL read 0 and ignore writes at all other addresses, still acking normally.
REQ-020 SHALL drive haltreq_o[hartsel] = haltreq & dmactive, and hartreset_o[hartsel] = hartreset & dmactive; all other bits 0.
REQ-021 SHALL, on a dmcontrol write with resumereq=1, haltreq=0 and dmactive=1, pulse resumereq_o[hartsel] for exactly one cycle and clear that hart's resumeack.
REQ-022 SHALL set a hart's resumeack when hart_halted_i for that hart is 0 after its resume pulse.
REQ-023 SHALL give haltreq priority: write with haltreq=1 and resumereq=1 asserts halt, no resume pulse.
REQ-024 SHALL, when hartsel >= NUM_HARTS, report anynonexistent=1, all halted/running/resumeack bits 0, and drive no request outputs.
REQ-025 SHALL, while dmactive=0, hold all requests low, clear resumeack and dataN, and accept only dmactive in dmcontrol writes.

Reset
REQ-026 SHALL asynchronously on rst_i force FSM to IDLE, ack_o=0, data_o=0, all request outputs 0, dmcontrol=0, dataN=0, resumeack=0.
REQ-027 SHALL on reset mid-transaction drop ack_o immediately; after release, a still-asserted cyc_i&stb_i starts a new transaction.

Configuration
REQ-028 SHALL with DM_WB_SLAVE_PRINTF_EN defined add outputs send_data (8 bits) and printf (1 bit): on every committed dmcontrol write, send_data = 0x00 haltreq / 0x01 resumereq / 0x02 hartreset / 0x03 none, printf toggles.
REQ-029 SHALL without DM_WB_SLAVE_PRINTF_EN omit those ports and logic entirely.

Structure
REQ-030 SHALL place register addresses, dmcontrol/dmstatus bit positions, dmstatus version and FSM state encoding in shared package dm_pkg.
REQ-031 SHALL instantiate one sub-module dm_hart_ctrl per hart (generate loop) owning haltreq/hartreset/resume pulse/resumeack for that hart.

Verification
REQ-032 SHALL cover: write 0x10=0x8000_0001 (hartsel 0) -> ack 1 cycle after stb, haltreq_o=0001; hart_halted_i=0001 -> read 0x11 = 0x0000_0302 | anyrunning/allrunning bits clear.
REQ-033 SHALL cover: write 0x10=0x4001_0001 with hart 1 halted -> resumereq_o=0010 for one cycle; drop hart_halted_i[1] -> 0x11 bit17=1.
REQ-034 SHALL cover: stb_i held 10 cycles on write 0x04=0xDEAD -> single commit, ack_o high cycles 2..10, low the cycle after stb_i drops; read 0x04 -> 0xDEAD.
REQ-035 SHALL cover: hartsel=7 with NUM_HARTS=4 -> dmstatus bit14=1, all request outputs 0; write with dmactive=0 -> data0 reads 0.
REQ-036 SHALL cover: rst_i mid-ACK -> ack_o and haltreq_o go 0 without a clock edge; write 0xC000_0001 -> halt only, no resume pulse.
